// File: rtl/branch_resolver_if.sv
// Execute-stage bundle between the upstream pipeline/fetch (master) and the branch resolver (slave).
// Carries the instruction/flag inputs, the redirect handshake, link writeback and status outputs.
interface branch_resolver_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             is_branch;
  logic             is_jal;
  logic             is_jalr;
  logic             is_compressed;
  logic [2:0]       funct3;
  logic             flag_z;
  logic             flag_s;
  logic             flag_c;
  logic             flag_v;
  logic [31:0]      pc;
  logic [31:0]      imm;
  logic [31:0]      alu_result;
  logic             redir_valid;
  logic             redir_ready;
  logic [31:0]      redir_pc;
  logic             link_valid;
  logic [31:0]      link_data;
  logic             flush;
  logic             illegal;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output in_valid, is_branch, is_jal, is_jalr, is_compressed, funct3,
           flag_z, flag_s, flag_c, flag_v, pc, imm, alu_result, redir_ready,
    input  in_ready, redir_valid, redir_pc, link_valid, link_data, flush,
           illegal, taken_cnt
  );

  modport slave (
    input  in_valid, is_branch, is_jal, is_jalr, is_compressed, funct3,
           flag_z, flag_s, flag_c, flag_v, pc, imm, alu_result, redir_ready,
    output in_ready, redir_valid, redir_pc, link_valid, link_data, flush,
           illegal, taken_cnt
  );
endinterface

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: evaluates ALU flags for control transfers, issues a PC
// redirect to fetch, produces the link value and holds flush for FLUSH_CYCLES afterwards.
module branch_resolver #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst,
  branch_resolver_if.slave rsv
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  // Counter only needs to hold FLUSH_CYCLES-1; keep at least one bit so FLUSH_CYCLES=0 still elaborates.
  localparam int               FC_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  state_t           state;
  logic [FC_W-1:0]  flush_left;
  logic [CNT_W-1:0] cnt_q;

  logic        accept;
  logic        cond;
  logic        bad_f3;
  logic        taken;
  logic        is_link;
  logic        illegal_d;
  logic [31:0] target;
  logic [31:0] link_val;

  assign rsv.in_ready  = (state == IDLE);
  assign rsv.taken_cnt = cnt_q;
  assign accept        = rsv.in_valid & rsv.in_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cond      = 1'b0;
    bad_f3    = 1'b0;
    taken     = 1'b0;
    is_link   = 1'b0;
    illegal_d = 1'b0;
    target    = rsv.pc + rsv.imm;
    link_val  = rsv.pc + (rsv.is_compressed ? 32'd2 : 32'd4);

    case (rsv.funct3)
      3'b000:         cond = rsv.flag_z;
      3'b001:         cond = ~rsv.flag_z;
      3'b100:         cond = rsv.flag_s ^ rsv.flag_v;
      3'b101:         cond = ~(rsv.flag_s ^ rsv.flag_v);
      3'b110:         cond = ~rsv.flag_c;
      3'b111:         cond = rsv.flag_c;
      default:        bad_f3 = 1'b1;
    endcase

    if (rsv.is_jalr) begin
      taken   = 1'b1;
      is_link = 1'b1;
      target  = {rsv.alu_result[31:1], 1'b0};
    end else if (rsv.is_jal) begin
      taken   = 1'b1;
      is_link = 1'b1;
    end else if (rsv.is_branch) begin
      taken     = cond;
      illegal_d = bad_f3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      flush_left      <= '0;
      cnt_q           <= '0;
      rsv.redir_valid <= 1'b0;
      rsv.redir_pc    <= '0;
      rsv.link_valid  <= 1'b0;
      rsv.link_data   <= '0;
      rsv.flush       <= 1'b0;
      rsv.illegal     <= 1'b0;
    end else begin
      rsv.link_valid <= 1'b0;
      rsv.illegal    <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            rsv.illegal <= illegal_d;
            if (is_link) begin
              rsv.link_valid <= 1'b1;
              rsv.link_data  <= link_val;
            end
            if (taken) begin
              state           <= REDIRECT;
              rsv.redir_valid <= 1'b1;
              rsv.redir_pc    <= target;
            end
          end
        end

        REDIRECT: begin
          if (rsv.redir_ready) begin
            rsv.redir_valid <= 1'b0;
            cnt_q           <= cnt_q + CNT_W'(1);
            if (FLUSH_CYCLES > 0) begin
              state      <= FLUSH;
              rsv.flush  <= 1'b1;
              flush_left <= FLUSH_LAST;
            end else begin
              state <= IDLE;
            end
          end
        end

        FLUSH: begin
          if (flush_left == '0) begin
            rsv.flush <= 1'b0;
            state     <= IDLE;
          end else begin
            flush_left <= flush_left - FC_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: inputs change on the falling edge, outputs are
// checked on the falling edge, against hand-computed expectations.
module tb_branch_resolver;

  localparam int CNT_W = 16;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  branch_resolver_if #(.CNT_W(CNT_W)) bif ();

  branch_resolver #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .rsv (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bif.in_valid      = 1'b0;
    bif.is_branch     = 1'b0;
    bif.is_jal        = 1'b0;
    bif.is_jalr       = 1'b0;
    bif.is_compressed = 1'b0;
    bif.funct3        = 3'b000;
    bif.flag_z        = 1'b0;
    bif.flag_s        = 1'b0;
    bif.flag_c        = 1'b0;
    bif.flag_v        = 1'b0;
    bif.pc            = 32'h0;
    bif.imm           = 32'h0;
    bif.alu_result    = 32'h0;
    bif.redir_ready   = 1'b0;
  endtask

  task automatic issue_branch(input logic [2:0] f3, input logic z, input logic s,
                              input logic c, input logic v,
                              input logic [31:0] pc, input logic [31:0] imm);
    clear_inputs();
    bif.in_valid  = 1'b1;
    bif.is_branch = 1'b1;
    bif.funct3    = f3;
    bif.flag_z    = z;
    bif.flag_s    = s;
    bif.flag_c    = c;
    bif.flag_v    = v;
    bif.pc        = pc;
    bif.imm       = imm;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bif.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bif.in_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout waiting for in_ready, got %b want 1", name, bif.in_ready);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bif.redir_valid, bif.link_valid, bif.flush, bif.illegal} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000",
               {bif.redir_valid, bif.link_valid, bif.flush, bif.illegal});
    end
    vectors++;
    if (bif.redir_pc !== 32'h0 || bif.link_data !== 32'h0 || bif.taken_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_data: got pc=%h link=%h cnt=%h want 0/0/0",
               bif.redir_pc, bif.link_data, bif.taken_cnt);
    end
    vectors++;
    if (bif.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", bif.in_ready);
    end
  endtask

  task automatic test_not_taken_b2b();
    // BLTU with c=1 (a>=b) then BGE with s^v=1 (a<b): neither is taken.
    issue_branch(3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h40);
    @(negedge clk);
    vectors++;
    if (bif.in_ready !== 1'b1 || bif.redir_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bltu_not_taken: got ready=%b rv=%b want 1/0", bif.in_ready, bif.redir_valid);
    end
    issue_branch(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 32'h40);
    @(negedge clk);
    clear_inputs();
    vectors++;
    if (bif.in_ready !== 1'b1 || bif.redir_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bge_not_taken: got ready=%b rv=%b want 1/0", bif.in_ready, bif.redir_valid);
    end
    @(negedge clk);
    vectors++;
    if (bif.taken_cnt !== 16'd0 || bif.flush !== 1'b0 || bif.link_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL not_taken_side: got cnt=%0d flush=%b lv=%b want 0/0/0",
               bif.taken_cnt, bif.flush, bif.link_valid);
    end
  endtask

  task automatic test_beq_taken();
    issue_branch(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h20);
    bif.redir_ready = 1'b1;
    @(negedge clk);
    bif.in_valid = 1'b0;
    vectors++;
    if (bif.redir_valid !== 1'b1 || bif.redir_pc !== 32'h120 || bif.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL beq_redirect: got rv=%b pc=%h ready=%b want 1/00000120/0",
               bif.redir_valid, bif.redir_pc, bif.in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (bif.flush !== 1'b1 || bif.redir_valid !== 1'b0 || bif.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL beq_flush%0d: got flush=%b rv=%b ready=%b want 1/0/0",
                 i, bif.flush, bif.redir_valid, bif.in_ready);
      end
    end
    @(negedge clk);
    vectors++;
    if (bif.flush !== 1'b0 || bif.in_ready !== 1'b1 || bif.taken_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL beq_done: got flush=%b ready=%b cnt=%0d want 0/1/1",
               bif.flush, bif.in_ready, bif.taken_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_jalr_compressed();
    clear_inputs();
    bif.in_valid      = 1'b1;
    bif.is_jalr       = 1'b1;
    bif.is_branch     = 1'b1;   // lower-priority type bit must be ignored
    bif.funct3        = 3'b010;
    bif.is_compressed = 1'b1;
    bif.pc            = 32'h400;
    bif.alu_result    = 32'h2003;
    bif.redir_ready   = 1'b1;
    @(negedge clk);
    bif.in_valid = 1'b0;
    vectors++;
    if (bif.redir_valid !== 1'b1 || bif.redir_pc !== 32'h2002) begin
      miscompares++;
      $display("FAIL jalr_target: got rv=%b pc=%h want 1/00002002", bif.redir_valid, bif.redir_pc);
    end
    vectors++;
    if (bif.link_valid !== 1'b1 || bif.link_data !== 32'h402 || bif.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL jalr_link: got lv=%b data=%h ill=%b want 1/00000402/0",
               bif.link_valid, bif.link_data, bif.illegal);
    end
    @(negedge clk);
    vectors++;
    if (bif.link_valid !== 1'b0 || bif.link_data !== 32'h402 || bif.taken_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL jalr_after: got lv=%b data=%h cnt=%0d want 0/00000402/2",
               bif.link_valid, bif.link_data, bif.taken_cnt);
    end
    clear_inputs();
    wait_idle("jalr_idle");
  endtask

  task automatic test_jal_stall();
    clear_inputs();
    bif.in_valid = 1'b1;
    bif.is_jal   = 1'b1;
    bif.pc       = 32'hFFFF_FFF8;
    bif.imm      = 32'h10;
    @(negedge clk);
    bif.in_valid = 1'b0;
    vectors++;
    if (bif.link_valid !== 1'b1 || bif.link_data !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL jal_link: got lv=%b data=%h want 1/fffffffc", bif.link_valid, bif.link_data);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bif.redir_valid !== 1'b1 || bif.redir_pc !== 32'h8 || bif.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL jal_stall%0d: got rv=%b pc=%h ready=%b want 1/00000008/0",
                 i, bif.redir_valid, bif.redir_pc, bif.in_ready);
      end
      if (i == 3) bif.redir_ready = 1'b1;
      @(negedge clk);
    end
    bif.redir_ready = 1'b0;
    vectors++;
    if (bif.redir_valid !== 1'b0 || bif.flush !== 1'b1 || bif.taken_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL jal_release: got rv=%b flush=%b cnt=%0d want 0/1/3",
               bif.redir_valid, bif.flush, bif.taken_cnt);
    end
    wait_idle("jal_idle");
  endtask

  task automatic test_illegal();
    issue_branch(3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h8);
    bif.redir_ready = 1'b1;
    @(negedge clk);
    clear_inputs();
    vectors++;
    if (bif.illegal !== 1'b1 || bif.redir_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_pulse: got ill=%b rv=%b ready=%b want 1/0/1",
               bif.illegal, bif.redir_valid, bif.in_ready);
    end
    @(negedge clk);
    vectors++;
    if (bif.illegal !== 1'b0 || bif.taken_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL illegal_end: got ill=%b cnt=%0d want 0/3", bif.illegal, bif.taken_cnt);
    end
  endtask

  task automatic test_reset_mid_flush();
    issue_branch(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600, 32'h4);
    bif.redir_ready = 1'b1;
    @(negedge clk);
    bif.in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bif.flush !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_flush: got %b want 1", bif.flush);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bif.flush !== 1'b0 || bif.in_ready !== 1'b1 || bif.taken_cnt !== 16'd0 || bif.redir_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got flush=%b ready=%b cnt=%0d rv=%b want 0/1/0/0",
               bif.flush, bif.in_ready, bif.taken_cnt, bif.redir_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    issue_branch(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 32'hFFFF_FF00);
    bif.redir_ready = 1'b0;
    @(negedge clk);
    bif.in_valid = 1'b0;
    vectors++;
    if (bif.redir_valid !== 1'b1 || bif.redir_pc !== 32'h200 || bif.link_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bne_after_reset: got rv=%b pc=%h lv=%b want 1/00000200/0",
               bif.redir_valid, bif.redir_pc, bif.link_valid);
    end
    bif.redir_ready = 1'b1;
    @(negedge clk);
    bif.redir_ready = 1'b0;
    vectors++;
    if (bif.taken_cnt !== 16'd1 || bif.flush !== 1'b1) begin
      miscompares++;
      $display("FAIL bne_count: got cnt=%0d flush=%b want 1/1", bif.taken_cnt, bif.flush);
    end
    wait_idle("bne_idle");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_not_taken_b2b();
    test_beq_taken();
    test_jalr_compressed();
    test_jal_stall();
    test_illegal();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumes the ALU flag outputs (z, s, c, v) and the ALU result for a control-transfer instruction, and decides whether the PC must be redirected.
- Computes the target address and the link (return) value.
- Drives a redirect handshake to fetch, then asserts a pipeline flush for a fixed number of cycles.
- Sits in the execute stage, directly downstream of the ALU.

Parameters:
- FLUSH_CYCLES, 2, cycles flush stays high after a redirect is accepted (0 allowed).
- CNT_W, 16, width of the taken-transfer counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  execute-stage instruction present
- in_ready  output  1  resolver can accept an instruction
- is_branch  input  1  conditional branch (B-type)
- is_jal  input  1  JAL / C.JAL / C.J
- is_jalr  input  1  JALR / C.JR / C.JALR
- is_compressed  input  1  16-bit instruction (link = pc+2, else pc+4)
- funct3  input  3  branch condition code
- flag_z  input  1  ALU zero flag of a-b
- flag_s  input  1  ALU sign flag of a-b
- flag_c  input  1  ALU carry-out of a+~b+1 (1 means a>=b unsigned)
- flag_v  input  1  ALU overflow flag of a-b
- pc  input  32  instruction PC
- imm  input  32  sign-extended offset
- alu_result  input  32  rs1+imm for JALR
- redir_valid  output  1  redirect request to fetch
- redir_ready  input  1  fetch accepts redirect
- redir_pc  output  32  redirect target
- link_valid  output  1  one-cycle pulse: link_data is valid for rd writeback
- link_data  output  32  return address
- flush  output  1  squash younger pipeline stages
- illegal  output  1  one-cycle pulse on an undefined branch funct3
- taken_cnt  output  CNT_W  count of accepted redirects, wraps

Behaviour:
- Reset (async, any state): state=IDLE.
- Reset values: redir_valid=0, redir_pc=0, link_valid=0, link_data=0, flush=0, illegal=0, taken_cnt=0.
- States: IDLE, REDIRECT, FLUSH.
- in_ready=1 only in IDLE.
- Accept: an instruction is accepted on a rising edge with in_valid & in_ready. All inputs are sampled there and ignored at every other time.
- Priority when several type bits are set: is_jalr > is_jal > is_branch.
- If none of the type bits is set: no action, stay IDLE.
- Branch condition by funct3:
  - 000 BEQ: z
  - 001 BNE: !z
  - 100 BLT: s^v
  - 101 BGE: !(s^v)
  - 110 BLTU: !c
  - 111 BGEU: c
  - 010 / 011: not taken; illegal pulses for 1 cycle, 1 cycle after accept.
- Targets (32-bit modulo arithmetic, wrap-around silently discarded):
  - branch / JAL: pc+imm
  - JALR: alu_result with bit 0 cleared
- Link value: link_data = pc+2 if is_compressed, else pc+4.
  - Registered 1 cycle after accept, with link_valid pulsing for exactly that cycle.
  - Produced for JAL/JALR only; link_data holds its last value otherwise.
- Taken (JAL, JALR, or branch condition true):
  - Next cycle: state=REDIRECT, redir_valid=1, redir_pc=target.
  - redir_pc stays stable while waiting; redir_valid stays high until redir_ready.
- REDIRECT with redir_ready=1 on an edge:
  - redir_valid drops next cycle and taken_cnt increments.
  - If FLUSH_CYCLES>0: state=FLUSH and flush=1 for exactly FLUSH_CYCLES cycles, then IDLE.
  - If FLUSH_CYCLES=0: straight to IDLE.
- Not taken: stay IDLE. Back-to-back accepts are allowed every cycle.
- Latency: accept edge to redir_valid high = 1 cycle.
- redir_ready is ignored outside REDIRECT.
- in_valid while not in IDLE: not accepted; upstream must hold the instruction.
- taken_cnt wraps from all-ones to 0.
- Reset asserted in REDIRECT or FLUSH: outputs clear immediately (asynchronous); the pending redirect is lost.

Test Plan:
- BEQ, flag_z=1, pc=0x100, imm=0x20, redir_ready=1 -> redir_valid high 1 cycle after accept, redir_pc=0x120; flush high 2 cycles; taken_cnt=1; in_ready returns after flush.
- BLTU with c=1, then BGE with s=1 v=0, back-to-back -> both not taken; in_ready stays 1; no redirect; taken_cnt=0.
- Compressed JALR, alu_result=0x2003, pc=0x400 -> redir_pc=0x2002; link_valid pulse with link_data=0x402.
- JAL, pc=0xFFFFFFF8, imm=0x10, redir_ready held 0 for 3 cycles -> redir_pc=0x00000008 held stable with redir_valid high for 4 cycles; in_ready=0 throughout.
- funct3=010 branch -> illegal pulses 1 cycle; no redirect.
- Reset asserted mid-FLUSH -> flush=0 immediately, state IDLE, taken_cnt=0; next BNE with z=0 redirects normally.
